exec_sequencer: RTL and testbench
=================================

# exec_sequencer

- Execution controller between the board push-buttons and the CPU datapath.
- Synchronizes and debounces the EXEC and STEP buttons.
- Sequences power-on reset into the core, then runs or halts the datapath through a single clock-enable. It does not gate the clock.
- Also handles single-step and software halt requests, and counts executed cycles for the status display.

## Interface
Parameters:
- DEB_CYCLES, 4: consecutive stable samples needed to accept a button level change (≥1).
- RST_HOLD, 8: cycles RES_SIG stays high after RESET deasserts (≥1).
- CNT_W, 16: width of CYC_CNT.

Ports:
- CLOCK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- EXEC  in  1  raw run/halt button, asynchronous, active-high.
- STEP  in  1  raw single-step button, asynchronous, active-high.
- HALT_REQ  in  1  level from CPU; halt instruction reached, synchronous to CLOCK.
- CPU_EN  out  1  datapath clock-enable.
- RES_SIG  out  1  reset to datapath, active-high.
- RUNNING  out  1  high while in S_RUN.
- CYC_CNT  out  CNT_W  count of cycles with CPU_EN=1.

## Operation
- Each button path:
  - 2-flop synchronizer.
  - Debouncer holding a debounced level. The level flips only after the synchronized input differs from it for DEB_CYCLES consecutive cycles; any agreeing sample clears the count.
  - Rising edge of the debounced level gives a 1-cycle press pulse (exec_p, step_p).
- FSM states: S_RST, S_HALT, S_RUN, S_STEP.
- S_RST:
  - RES_SIG=1, CPU_EN=0.
  - Hold counter counts RST_HOLD cycles after RESET release, then goes to S_HALT.
  - Button presses are ignored.
- S_HALT:
  - exec_p → S_RUN.
  - Else step_p → S_STEP.
  - exec_p and step_p in the same cycle: exec wins.
  - exec_p is honored even if HALT_REQ=1; the CPU gets at least one enabled cycle to advance past the halt.
- S_RUN:
  - CPU_EN=1.
  - exec_p or HALT_REQ=1 → S_HALT.
  - step_p is ignored.
- S_STEP: CPU_EN=1 for exactly one cycle, then S_HALT unconditionally. Presses in this cycle are ignored.
- Registered outputs:
  - CPU_EN = (state ∈ {S_RUN, S_STEP}).
  - RUNNING = (state == S_RUN).
  - RES_SIG = (state == S_RST).
- CYC_CNT:
  - Increments by 1 in every cycle CPU_EN=1.
  - Saturates at 2^CNT_W−1; does not wrap.
  - Cleared in S_RST.
- Reset values (async, on RESET=1):
  - state=S_RST, RES_SIG=1, CPU_EN=0, RUNNING=0, CYC_CNT=0.
  - Synchronizers, debounced levels, debounce and hold counters all 0.
- RESET mid-run: immediate async return to S_RST, CPU_EN drops the same instant, full RST_HOLD replays.

## Timing
- Button latency: raw edge → press pulse = 2 (sync) + DEB_CYCLES + 1 cycles.
- FSM reacts on the cycle after the pulse.
- HALT_REQ sampled high in S_RUN: CPU_EN is 1 in that cycle and 0 from the next.
- RES_SIG low exactly RST_HOLD+1 posedges after RESET falls. The first posedge after release leaves the hold count at 1.
- A press is one event: a held button produces one pulse; release needs DEB_CYCLES stable cycles before the next press counts.

## Configuration
- SEQ_SINGLE_STEP_EN defined:
  - STEP path (synchronizer, debouncer, S_STEP) is built as above.
- Not defined:
  - STEP port remains but is ignored.
  - step_p is tied 0 and S_STEP is unreachable; the encoding is still reserved.
  - The only way out of S_HALT is exec_p.

## Structure
- Package exec_seq_pkg holds:
  - State enum seq_state_t (S_RST, S_HALT, S_RUN, S_STEP).
  - Default constants DEB_CYCLES_DEF, RST_HOLD_DEF.
- Sub-module btn_debounce (synchronizer + debouncer + edge pulse, parameter DEB_CYCLES), instantiated for EXEC and STEP.
- FSM, hold counter and CYC_CNT live in exec_sequencer.

## Test plan
- Reset, RST_HOLD=8 → RES_SIG=1 for 8 posedges after release, then 0; CPU_EN=0, CYC_CNT=0 throughout.
- Bounce: EXEC toggles every 2 cycles for 10 cycles, then steady high (DEB_CYCLES=4) → one exec_p, S_RUN entered once, CPU_EN=1 from then on.
- Run then HALT_REQ=1 after 20 enabled cycles → CPU_EN falls the next cycle, RUNNING=0, CYC_CNT=20.
- Single step (macro on): three separate STEP presses from S_HALT → three single-cycle CPU_EN pulses, CYC_CNT=3. Macro off: same stimulus → CPU_EN stays 0.
- EXEC and STEP debounced on the same cycle in S_HALT → S_RUN, no S_STEP.
- RESET asserted mid-run, CNT_W=4 counter previously saturated at 15 → CPU_EN=0 immediately, CYC_CNT=0, RES_SIG high for RST_HOLD cycles after release.

Source files
------------

// File: rtl/exec_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_seq_pkg
// Description : Shared state encoding, default constants and width helper
//               for the execution sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_seq_pkg;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_HALT = 2'd1,
        S_RUN  = 2'd2,
        S_STEP = 2'd3
    } seq_state_t;

    localparam int DEB_CYCLES_DEF = 4;
    localparam int RST_HOLD_DEF   = 8;
    localparam int CNT_W_DEF      = 16;

    // Bits needed to hold every value 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_sequencer_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, counting debouncer and rising-edge
//               press pulse for one raw push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import exec_seq_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int               CW         = cnt_width(DEB_CYCLES);
    localparam logic [CW-1:0]    C_DEB_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          prev_q,  prev_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = i_btn;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        prev_d  = level_q;
        press_d = level_q & ~prev_q;
        // Any sample agreeing with the held level restarts the stability run.
        if (sync2_q != level_q) begin
            if (cnt_q == C_DEB_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_press = press_q;

endmodule
`default_nettype wire

// File: rtl/exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : exec_sequencer
// Description : Run/halt/step controller driving the datapath clock-enable,
//               reset sequencing and executed-cycle counter.
//               Macro SEQ_SINGLE_STEP_EN builds the single-step path.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int RST_HOLD   = RST_HOLD_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             EXEC,
    input  logic             STEP,
    input  logic             HALT_REQ,
    output logic             CPU_EN,
    output logic             RES_SIG,
    output logic             RUNNING,
    output logic [CNT_W-1:0] CYC_CNT
);

    localparam int               HW          = cnt_width(RST_HOLD);
    localparam logic [HW-1:0]    C_HOLD_DONE = HW'(RST_HOLD);
    localparam logic [CNT_W-1:0] C_CYC_MAX   = '1;

    logic w_exec_p;
    logic w_step_p;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_exec_deb (
        .clk     (CLOCK),
        .rst     (RESET),
        .i_btn   (EXEC),
        .o_press (w_exec_p)
    );

`ifdef SEQ_SINGLE_STEP_EN
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk     (CLOCK),
        .rst     (RESET),
        .i_btn   (STEP),
        .o_press (w_step_p)
    );
`else
    logic w_unused_step;
    assign w_unused_step = STEP;
    assign w_step_p      = 1'b0;
`endif

    seq_state_t       state_q, state_d;
    logic [HW-1:0]    hold_q,  hold_d;
    logic [CNT_W-1:0] cyc_q,   cyc_d;
    logic             cpu_en_q,  cpu_en_d;
    logic             running_q, running_d;
    logic             res_sig_q, res_sig_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cyc_d   = cyc_q;
        case (state_q)
            S_RST: begin
                if (hold_q == C_HOLD_DONE) begin
                    state_d = S_HALT;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_HALT: begin
                if (w_exec_p) begin
                    state_d = S_RUN;
                end else if (w_step_p) begin
                    state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (w_exec_p || HALT_REQ) begin
                    state_d = S_HALT;
                end
            end
            S_STEP: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RST;
            end
        endcase

        // Counts the enabled cycle that is ending at this edge.
        if (state_q == S_RST) begin
            cyc_d = '0;
        end else if (cpu_en_q && (cyc_q != C_CYC_MAX)) begin
            cyc_d = cyc_q + CNT_W'(1);
        end

        cpu_en_d  = (state_d == S_RUN) || (state_d == S_STEP);
        running_d = (state_d == S_RUN);
        res_sig_d = (state_d == S_RST);
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_RST;
            hold_q    <= '0;
            cyc_q     <= '0;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            res_sig_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            cyc_q     <= cyc_d;
            cpu_en_q  <= cpu_en_d;
            running_q <= running_d;
            res_sig_q <= res_sig_d;
        end
    end

    assign CPU_EN  = cpu_en_q;
    assign RUNNING = running_q;
    assign RES_SIG = res_sig_q;
    assign CYC_CNT = cyc_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_sequencer
// Description : Self-checking bench for exec_sequencer with a cycle-level
//               reference model, phase table and directed corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_sequencer;

    localparam int DEB  = 4;
    localparam int HOLD = 8;
`ifdef SEQ_SINGLE_STEP_EN
    localparam bit STEP_ON = 1'b1;
`else
    localparam bit STEP_ON = 1'b0;
`endif
    localparam int M_RST = 0, M_HALT = 1, M_RUN = 2, M_STEP = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exec_btn = 1'b0, step_btn = 1'b0, halt_req = 1'b0;
    logic        cpu_en, res_sig, running;
    logic [15:0] cyc_cnt;
    logic        cpu_en4, res_sig4, running4;
    logic [3:0]  cyc_cnt4;

    always #5 clk = ~clk;

    exec_sequencer #(.DEB_CYCLES(DEB), .RST_HOLD(HOLD), .CNT_W(16)) dut (
        .CLOCK(clk), .RESET(rst), .EXEC(exec_btn), .STEP(step_btn), .HALT_REQ(halt_req),
        .CPU_EN(cpu_en), .RES_SIG(res_sig), .RUNNING(running), .CYC_CNT(cyc_cnt));

    exec_sequencer #(.DEB_CYCLES(DEB), .RST_HOLD(HOLD), .CNT_W(4)) dut4 (
        .CLOCK(clk), .RESET(rst), .EXEC(exec_btn), .STEP(step_btn), .HALT_REQ(halt_req),
        .CPU_EN(cpu_en4), .RES_SIG(res_sig4), .RUNNING(running4), .CYC_CNT(cyc_cnt4));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: raw-sample history per button, plain integer state.
    int     m_state, m_hold_edges;
    longint m_cyc, m_cyc4;
    bit     m_hist [2][16];
    bit     m_lvl [2], m_lvl_prev [2], m_pulse [2];

    function automatic void model_reset();
        m_state = M_RST; m_hold_edges = 0; m_cyc = 0; m_cyc4 = 0;
        for (int b = 0; b < 2; b++) begin
            m_lvl[b] = 0; m_lvl_prev[b] = 0; m_pulse[b] = 0;
            for (int k = 0; k < 16; k++) m_hist[b][k] = 0;
        end
    endfunction

    function automatic void model_edge();
        bit raw [2];
        bit p_old [2];
        bit all_diff;
        int st_old;
        raw[0] = exec_btn; raw[1] = step_btn;
        p_old[0] = m_pulse[0]; p_old[1] = STEP_ON ? m_pulse[1] : 1'b0;
        st_old = m_state;
        for (int b = 0; b < 2; b++) begin
            m_pulse[b] = m_lvl[b] && !m_lvl_prev[b];
            // The level flips once the last DEB synchronized samples all disagree.
            all_diff = 1;
            for (int k = 1; k <= DEB; k++) if (m_hist[b][k] == m_lvl[b]) all_diff = 0;
            m_lvl_prev[b] = m_lvl[b];
            if (all_diff) m_lvl[b] = !m_lvl[b];
            for (int k = 15; k > 0; k--) m_hist[b][k] = m_hist[b][k-1];
            m_hist[b][0] = raw[b];
        end
        case (st_old)
            M_RST: begin
                m_hold_edges++;
                if (m_hold_edges == HOLD + 1) m_state = M_HALT;
            end
            M_HALT: if (p_old[0]) m_state = M_RUN; else if (p_old[1]) m_state = M_STEP;
            M_RUN:  if (p_old[0] || halt_req) m_state = M_HALT;
            default: m_state = M_HALT;
        endcase
        if (st_old == M_RST) begin
            m_cyc = 0; m_cyc4 = 0;
        end else if (st_old == M_RUN || st_old == M_STEP) begin
            m_cyc  = (m_cyc  < 65535) ? m_cyc  + 1 : m_cyc;
            m_cyc4 = (m_cyc4 < 15)    ? m_cyc4 + 1 : m_cyc4;
        end
    endfunction

    int mon_run_rises, mon_en_cycles, mon_streak, mon_max_streak;
    bit mon_prev_run;

    function automatic void mon_clear();
        mon_run_rises = 0; mon_en_cycles = 0; mon_streak = 0; mon_max_streak = 0;
        mon_prev_run = running;
    endfunction

    task automatic compare_all();
        logic exp_en;
        exp_en = (m_state == M_RUN) || (m_state == M_STEP);
        chk("cpu_en",   cpu_en,   exp_en);
        chk("running",  running,  m_state == M_RUN);
        chk("res_sig",  res_sig,  m_state == M_RST);
        chk("cyc_cnt",  cyc_cnt,  m_cyc);
        chk("cpu_en4",  cpu_en4,  exp_en);
        chk("res_sig4", res_sig4, m_state == M_RST);
        chk("running4", running4, m_state == M_RUN);
        chk("cyc_cnt4", cyc_cnt4, m_cyc4);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        compare_all();
        if (running && !mon_prev_run) mon_run_rises++;
        mon_prev_run = running;
        if (cpu_en) begin
            mon_en_cycles++; mon_streak++;
            if (mon_streak > mon_max_streak) mon_max_streak = mon_streak;
        end else mon_streak = 0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic check_release();
        rst = 1'b0;
        for (int k = 1; k <= HOLD + 1; k++) begin
            cycle();
            chk("res_hold", res_sig, (k <= HOLD) ? 1'b1 : 1'b0);
        end
    endtask

    typedef struct {
        logic exec; logic step; logic halt; int n; logic exp_run; logic exp_en;
    } phase_t;
    phase_t tbl [14];

    initial begin
        bit   timed_out;
        int   budget;
        longint cyc_before;

        tbl[0]  = '{1'b1, 1'b0, 1'b1, 12, 1'b0, 1'b0};  // exec honoured despite HALT_REQ
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b1};  // held button: one press only
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b1};  // step ignored while running
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1,  2, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 10, 1'b1, 1'b1};  // simultaneous press: exec wins
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0};

        model_reset();
        mon_clear();
        cycles(3);
        chk("reset_cpu_en", cpu_en, 1'b0);
        chk("reset_res_sig", res_sig, 1'b1);
        chk("reset_cyc", cyc_cnt, 16'd0);
        check_release();

        // Bouncing EXEC then steady high.
        mon_clear();
        for (int i = 0; i < 10; i++) begin
            exec_btn = ((i / 2) % 2) == 0;
            cycle();
        end
        exec_btn = 1'b1;
        cycles(14);
        chk("bounce_run_entries", mon_run_rises, 1);
        chk("bounce_cpu_en", cpu_en, 1'b1);
        exec_btn = 1'b0;

        // HALT_REQ in the 20th enabled cycle.
        budget = 0; timed_out = 0;
        while (m_cyc != 19 && !timed_out) begin
            cycle();
            budget++;
            if (budget > 100) timed_out = 1;
        end
        chk("run20_timeout", timed_out, 1'b0);
        halt_req = 1'b1;
        cycle();
        chk("halt_cpu_en", cpu_en, 1'b0);
        chk("halt_running", running, 1'b0);
        chk("halt_cyc", cyc_cnt, 16'd20);
        halt_req = 1'b0;
        cycles(10);

        foreach (tbl[i]) begin
            exec_btn = tbl[i].exec; step_btn = tbl[i].step; halt_req = tbl[i].halt;
            cycles(tbl[i].n);
            chk($sformatf("phase%0d_running", i), running, tbl[i].exp_run);
            chk($sformatf("phase%0d_cpu_en", i), cpu_en, tbl[i].exp_en);
        end

        // Three separate step presses from halt.
        cyc_before = m_cyc;
        mon_clear();
        for (int p = 0; p < 3; p++) begin
            step_btn = 1'b1; cycles(10);
            step_btn = 1'b0; cycles(10);
        end
        chk("step_en_cycles", mon_en_cycles, STEP_ON ? 3 : 0);
        chk("step_pulse_width", mon_max_streak, STEP_ON ? 1 : 0);
        chk("step_cyc", cyc_cnt, cyc_before + (STEP_ON ? 3 : 0));

        // Saturated narrow counter, then asynchronous reset mid-run.
        chk("sat_cyc4", cyc_cnt4, 4'd15);
        exec_btn = 1'b1; cycles(10);
        exec_btn = 1'b0; cycles(5);
        chk("prereset_cpu_en", cpu_en, 1'b1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_cpu_en", cpu_en, 1'b0);
        chk("async_cpu_en4", cpu_en4, 1'b0);
        chk("async_res_sig", res_sig, 1'b1);
        chk("async_cyc", cyc_cnt, 16'd0);
        chk("async_cyc4", cyc_cnt4, 4'd0);
        cycles(2);
        check_release();

        // Randomized button/halt activity against the model.
        for (int s = 0; s < 40; s++) begin
            exec_btn = 1'($urandom_range(0, 1));
            step_btn = 1'($urandom_range(0, 1));
            halt_req = ($urandom_range(0, 3) == 0);
            cycles($urandom_range(1, 12));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
